// File: rtl/riscv_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : riscv_pkg                                                  |
// | Description : Shared RV32 definitions used by the execute-stage units:   |
// |               M-extension funct7/func3 codes and the state encoding of   |
// |               the iterative multiply/divide sequencer.                   |
// | Ports       : none (package)                                             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package riscv_pkg;

    // funct7 value that selects the M extension on OP instructions
    localparam logic [6:0] c_FUNCT7_MULDIV = 7'b0000001;

    // M-extension func3 codes
    localparam logic [2:0] c_FUNC3_MUL    = 3'b000;
    localparam logic [2:0] c_FUNC3_MULH   = 3'b001;
    localparam logic [2:0] c_FUNC3_MULHSU = 3'b010;
    localparam logic [2:0] c_FUNC3_MULHU  = 3'b011;
    localparam logic [2:0] c_FUNC3_DIV    = 3'b100;
    localparam logic [2:0] c_FUNC3_DIVU   = 3'b101;
    localparam logic [2:0] c_FUNC3_REM    = 3'b110;
    localparam logic [2:0] c_FUNC3_REMU   = 3'b111;

    // muldiv sequencer state encoding
    localparam int         c_MD_STATE_W = 2;
    localparam logic [1:0] c_MD_IDLE    = 2'd0;
    localparam logic [1:0] c_MD_CALC    = 2'd1;
    localparam logic [1:0] c_MD_FIXUP   = 2'd2;
    localparam logic [1:0] c_MD_DONE    = 2'd3;

endpackage
`default_nettype wire

// File: rtl/muldiv_signfix.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : muldiv_signfix                                             |
// | Description : Conditional two's-complement negation. Produces the        |
// |               magnitude of a signed operand when i_negate flags it as    |
// |               negative.                                                  |
// | Ports       : i_value  [WIDTH] value to condition                        |
// |               i_negate         1 = negate i_value                        |
// |               o_value  [WIDTH] i_value or -i_value                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module muldiv_signfix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_value,
    input  logic             i_negate,
    output logic [WIDTH-1:0] o_value
);

    assign o_value = i_negate ? (~i_value + WIDTH'(1)) : i_value;

endmodule
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : muldiv_seq                                                 |
// | Description : Iterative RV32M multiply/divide sequencer. Shift-add       |
// |               multiplier or restoring divider on operand magnitudes for  |
// |               XLEN cycles, then a one-cycle sign fixup. Division by zero |
// |               and signed overflow complete on a fast path.               |
// | Ports       : clk, rst            clock, async active-high reset         |
// |               in_valid/in_ready   request handshake (ready only in IDLE) |
// |               func3, rs1, rs2     operation and operands                 |
// |               flush               abort any in-flight operation          |
// |               out_valid/out_ready result handshake                       |
// |               result              final result, held between ops         |
// |               busy                execute-stage stall request            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module muldiv_seq
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int c_CNT_W = $clog2(XLEN);

    logic [c_MD_STATE_W-1:0] r_state;
    logic [c_CNT_W-1:0]      r_count;
    logic [2:0]              r_func3;
    logic                    r_neg_res;
    logic [XLEN-1:0]         r_opa;      // |multiplicand|, or |dividend| before loading
    logic [XLEN-1:0]         r_opb;      // |divisor|
    // Upper half: product high / partial remainder.
    // Lower half: multiplier bits still to consume / dividend bits shifting into quotient.
    logic [2*XLEN-1:0]       r_acc;
    logic [XLEN-1:0]         r_result;
    logic                    r_out_valid;

    // ---------------- operand decode at accept ----------------
    logic            w_sign_a_op;
    logic            w_sign_b_op;
    logic            w_a_neg;
    logic            w_b_neg;
    logic            w_neg_res;
    logic [XLEN-1:0] w_abs_a;
    logic [XLEN-1:0] w_abs_b;

    assign w_sign_a_op = (func3 == c_FUNC3_MULH) || (func3 == c_FUNC3_MULHSU) ||
                         (func3 == c_FUNC3_DIV)  || (func3 == c_FUNC3_REM);
    assign w_sign_b_op = (func3 == c_FUNC3_MULH) || (func3 == c_FUNC3_DIV) ||
                         (func3 == c_FUNC3_REM);
    assign w_a_neg     = w_sign_a_op && rs1[XLEN-1];
    assign w_b_neg     = w_sign_b_op && rs2[XLEN-1];

    always_comb begin
        w_neg_res = 1'b0;
        case (func3)
            c_FUNC3_MULH, c_FUNC3_DIV:   w_neg_res = w_a_neg ^ w_b_neg;
            c_FUNC3_MULHSU, c_FUNC3_REM: w_neg_res = w_a_neg;  // remainder follows the dividend
            default:                     w_neg_res = 1'b0;
        endcase
    end

    muldiv_signfix #(.WIDTH(XLEN)) u_abs_a (
        .i_value  (rs1),
        .i_negate (w_a_neg),
        .o_value  (w_abs_a)
    );

    muldiv_signfix #(.WIDTH(XLEN)) u_abs_b (
        .i_value  (rs2),
        .i_negate (w_b_neg),
        .o_value  (w_abs_b)
    );

    // ---------------- fast-path detection ----------------
    logic            w_div_zero;
    logic            w_div_ovf;
    logic            w_fast;
    logic [XLEN-1:0] w_fast_result;

    assign w_div_zero    = func3[2] && (rs2 == '0);
    assign w_div_ovf     = ((func3 == c_FUNC3_DIV) || (func3 == c_FUNC3_REM)) &&
                           (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
    assign w_fast        = w_div_zero || w_div_ovf;
    // func3[1] distinguishes REM/REMU from DIV/DIVU
    assign w_fast_result = w_div_zero ? (func3[1] ? rs1 : '1)
                                      : (func3[1] ? '0  : rs1);

    // ---------------- one iteration step ----------------
    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_mul_next;
    logic [XLEN:0]     w_div_shift;
    logic [XLEN:0]     w_div_diff;
    logic [2*XLEN-1:0] w_div_next;

    assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opa} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

    // Partial remainder is always below the divisor, so the shifted value is
    // below 2*divisor and the MSB of the XLEN+1-bit difference is its sign.
    assign w_div_shift = r_acc[2*XLEN-1:XLEN-1];
    assign w_div_diff  = w_div_shift - {1'b0, r_opb};
    assign w_div_next  = w_div_diff[XLEN]
                       ? {w_div_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                       : {w_div_diff[XLEN-1:0],  r_acc[XLEN-2:0], 1'b1};

    // ---------------- sign fixup ----------------
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_div_sel;
    logic [XLEN-1:0]   w_div_fix;
    logic [XLEN-1:0]   w_fix_result;

    assign w_prod_fix   = r_neg_res ? (~r_acc + (2*XLEN)'(1)) : r_acc;
    assign w_div_sel    = r_func3[1] ? r_acc[2*XLEN-1:XLEN] : r_acc[XLEN-1:0];
    assign w_div_fix    = r_neg_res ? (~w_div_sel + XLEN'(1)) : w_div_sel;
    assign w_fix_result = r_func3[2]            ? w_div_fix :
                          (r_func3[1:0] == 2'b00) ? r_acc[XLEN-1:0] :
                                                    w_prod_fix[2*XLEN-1:XLEN];

    // ---------------- sequencer ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_MD_IDLE;
            r_count     <= '0;
            r_func3     <= '0;
            r_neg_res   <= 1'b0;
            r_opa       <= '0;
            r_opb       <= '0;
            r_acc       <= '0;
            r_result    <= '0;
            r_out_valid <= 1'b0;
        end else if (flush && (r_state != c_MD_IDLE)) begin
            r_state     <= c_MD_IDLE;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                c_MD_IDLE: begin
                    if (in_valid && !flush) begin
                        r_func3   <= func3;
                        r_neg_res <= w_neg_res;
                        r_opa     <= w_abs_a;
                        r_opb     <= w_abs_b;
                        r_count   <= '0;
                        // Multiply consumes |rs2| from the low half; divide shifts |rs1| out of it.
                        r_acc     <= {{XLEN{1'b0}}, (func3[2] ? w_abs_a : w_abs_b)};
                        if (w_fast) begin
                            r_result    <= w_fast_result;
                            r_out_valid <= 1'b1;
                            r_state     <= c_MD_DONE;
                        end else begin
                            r_state     <= c_MD_CALC;
                        end
                    end
                end
                c_MD_CALC: begin
                    r_acc   <= r_func3[2] ? w_div_next : w_mul_next;
                    r_count <= r_count + c_CNT_W'(1);
                    if (r_count == c_CNT_W'(XLEN - 1)) begin
                        r_state <= c_MD_FIXUP;
                    end
                end
                c_MD_FIXUP: begin
                    r_result    <= w_fix_result;
                    r_out_valid <= 1'b1;
                    r_state     <= c_MD_DONE;
                end
                c_MD_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= c_MD_IDLE;
                    end
                end
                default: begin
                    r_state     <= c_MD_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == c_MD_IDLE);
    assign busy      = (r_state != c_MD_IDLE);
    assign out_valid = r_out_valid;
    assign result    = r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_muldiv_seq                                              |
// | Description : Self-checking bench for muldiv_seq. Directed RV32M cases,  |
// |               fast paths, backpressure, flush and async reset, then      |
// |               random operations against an arithmetic reference model.   |
// | Ports       : none                                                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_muldiv_seq;

    localparam int XLEN = 32;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      func3;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    int total = 0;
    int bad   = 0;

    muldiv_seq #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .func3     (func3),
        .rs1       (rs1),
        .rs2       (rs2),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: RV32M semantics from plain 64-bit arithmetic
    function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
        longint    sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (f3)
            3'd0: begin p = 64'(ua * ub); return p[31:0];  end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(sa / sb);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_fast(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && b == 0) return 1'b1;
        if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    // Present a request for one edge; returns #1 after the accept edge with
    // the operand inputs scrambled so later changes are proven harmless.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        func3    = f3;
        rs1      = a;
        rs2      = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rs1      = $urandom;
        rs2      = $urandom;
        func3    = 3'($urandom);
    endtask

    // Full operation: latency counted in cycles from the accept cycle (accept
    // cycle = 0, the cycle right after the accept edge = 1).
    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input int hold);
        logic [31:0] exp;
        int          lat;
        int          exp_lat;
        bit          ready_seen;
        exp        = ref_op(f3, a, b);
        exp_lat    = is_fast(f3, a, b) ? 1 : XLEN + 2;
        issue(f3, a, b);
        lat        = 1;
        ready_seen = 1'b0;
        while (!out_valid && lat < 200) begin
            if (in_ready || !busy) ready_seen = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
        check_val({name, " latency"}, lat, exp_lat);
        check_val({name, " ready_while_busy"}, {31'b0, ready_seen}, 32'd0);
        check_val({name, " result"}, result, exp);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            #1;
            check_val({name, " hold_result"}, result, exp);
            check_val({name, " hold_valid_busy"}, {30'b0, out_valid, busy}, 32'd3);
        end
        out_ready = 1'b1;
        #1;
        check_val({name, " no_back_to_back"}, {31'b0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_val({name, " release"}, {29'b0, out_valid, busy, in_ready}, 32'd1);
    endtask

    initial begin
        bit seen_valid;
        logic [2:0]  rf3;
        logic [31:0] ra, rb;

        rst       = 1'b1;
        in_valid  = 1'b0;
        func3     = '0;
        rs1       = '0;
        rs2       = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("reset outputs", {29'b0, out_valid, busy, in_ready}, 32'd1);
        check_val("reset result", result, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed arithmetic
        run_op("MUL",    3'd0, 32'd7,          32'hFFFF_FFFD, 0);
        run_op("MULHU",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 0);
        run_op("MULH",   3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 0);
        run_op("MULHSU", 3'd2, 32'hFFFF_FFFF,  32'd2,         0);
        run_op("MULHmin",3'd1, 32'h8000_0000,  32'h8000_0000, 0);
        run_op("DIV",    3'd4, 32'hFFFF_FFF9,  32'd2,         0);
        run_op("REM",    3'd6, 32'hFFFF_FFF9,  32'd2,         0);
        run_op("DIVU",   3'd5, 32'd100,        32'd7,         0);
        run_op("REMU",   3'd7, 32'd100,        32'd7,         0);
        // Fast paths
        run_op("DIV0",   3'd4, 32'h1234_5678,  32'd0,         0);
        run_op("REMU0",  3'd7, 32'h0000_1234,  32'd0,         0);
        run_op("DIVOVF", 3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 0);
        run_op("REMOVF", 3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 0);
        run_op("DIVUbig",3'd5, 32'h8000_0000,  32'hFFFF_FFFF, 0);
        // Backpressure
        run_op("BP",     3'd0, 32'h0001_2345,  32'h0000_0F0F, 5);

        // Flush during CALC: back to IDLE, no result ever appears
        issue(3'd1, 32'h1357_9BDF, 32'h2468_ACE0);
        repeat (9) @(posedge clk);
        #1;
        flush     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        flush     = 1'b0;
        out_ready = 1'b0;
        check_val("flush calc state", {29'b0, out_valid, busy, in_ready}, 32'd1);
        seen_valid = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid || busy) seen_valid = 1'b1;
        end
        check_val("flush no result", {31'b0, seen_valid}, 32'd0);

        // Flush in DONE beats out_ready; flush in IDLE blocks accept
        issue(3'd5, 32'd9, 32'd0);
        flush     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_val("flush done", {29'b0, out_valid, busy, in_ready}, 32'd1);
        in_valid = 1'b1;
        func3    = 3'd0;
        rs1      = 32'd3;
        rs2      = 32'd3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        check_val("flush idle no accept", {29'b0, out_valid, busy, in_ready}, 32'd1);
        run_op("after flush", 3'd6, 32'hFFFF_FF00, 32'd7, 0);

        // Asynchronous reset mid-CALC
        issue(3'd0, 32'hDEAD_BEEF, 32'h0BAD_F00D);
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_val("async rst outputs", {29'b0, out_valid, busy, in_ready}, 32'd1);
        check_val("async rst result", result, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_op("after rst", 3'd2, 32'h8000_0001, 32'hFFFF_FFFF, 0);

        // Random operations
        for (int n = 0; n < 40; n++) begin
            rf3 = 3'($urandom_range(0, 7));
            ra  = pick_operand();
            rb  = pick_operand();
            run_op($sformatf("rand%0d f3=%0d a=%h b=%h", n, rf3, ra, rb), rf3, ra, rb,
                   int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative sequencer for the RV32M multiply/divide operations, sitting beside the single-cycle ALU in the execute stage.
- Accepts one M-extension operation (func7 = 0000001) at a time over a valid/ready handshake.
- Runs a shift-add multiplier or a restoring divider for XLEN cycles, then applies sign correction.
- Holds the result until the pipeline consumes it; busy drives the hazard unit's execute stall.

Parameters:
XLEN, 32, operand and result width; the iteration count equals XLEN.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  operation request
in_ready  out  1  high only in IDLE
func3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1  in  XLEN  operand A (multiplicand / dividend)
rs2  in  XLEN  operand B (multiplier / divisor)
flush  in  1  abort the current operation (branch mispredict / trap)
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
result  out  XLEN  final result
busy  out  1  state != IDLE

Behaviour:
- Reset (async, any state): state=IDLE; counter, accumulators, result and all latched fields = 0; out_valid=0, busy=0, in_ready=1.
- FSM states: IDLE, CALC, FIXUP, DONE.
- Accept: an edge with state==IDLE and in_valid=1 latches func3, rs1, rs2, the operand signs, and the negate-result flag. It also latches the absolute values of the signed operands:
  - rs1 for MULH, MULHSU, DIV, REM;
  - rs2 for MULH, DIV, REM.
  - MUL uses the low word, so its sign handling is irrelevant; process it unsigned.
- Fast path (next state DONE; out_valid is high 1 cycle after accept):
  - rs2==0, DIV/DIVU: result = all ones.
  - rs2==0, REM/REMU: result = rs1.
  - DIV with rs1=0x80000000 and rs2=0xFFFFFFFF: result = 0x80000000.
  - REM with the same operands: result = 0.
- Normal path: IDLE -> CALC.
  - CALC performs one iteration per edge; the counter runs 0..XLEN-1.
  - Multiply: 2*XLEN product register, add-then-shift on the multiplier LSB.
  - Divide: restoring; shift the remainder in, trial subtract, set the quotient bit when the remainder is non-negative.
  - After the XLEN-th iteration, go to FIXUP.
  - FIXUP, one cycle, selects the result:
    - product[XLEN-1:0] for MUL;
    - product[2XLEN-1:XLEN] for the MULH variants, negated over the full 2XLEN width first when the sign flag is set;
    - quotient for DIV, negated if the operand signs differ;
    - remainder for REM, negated if rs1 was negative.
  - FIXUP -> DONE.
- Latency: out_valid first high XLEN+2 cycles after the accept edge (34 for XLEN=32).
- DONE: out_valid=1 and result stable. Hold while out_ready=0. An edge with out_ready=1 returns to IDLE with out_valid=0.
- No back-to-back issue: in_ready=0 in DONE, even when out_ready=1 in the same cycle.
- in_valid in a non-IDLE state is ignored; it is not queued.
- flush: any non-IDLE state -> IDLE on the next edge, out_valid=0, result discarded. flush has priority over out_ready and over accept; a request with flush=1 in IDLE is not accepted.
- Operand inputs may change after accept without effect.
- result is only meaningful while out_valid=1. It holds its last value otherwise, and reads 0 after reset.

Decomposition:
- Shared riscv_pkg:
  - M-extension func3 constants (FUNC3_MUL … FUNC3_REMU);
  - FUNCT7_MULDIV = 7'b0000001;
  - muldiv state encoding.
- Flat single module. Optional combinational sub-module muldiv_signfix for the abs/negate of operands and result, instantiated twice.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD -> result 0xFFFFFFEB; in_ready low for 34 cycles; out_valid at cycle 34.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU rs1=0xFFFFFFFF, rs2=2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
- Fast path: DIV x/0 -> 0xFFFFFFFF, REMU 0x1234/0 -> 0x1234, DIV 0x80000000/0xFFFFFFFF -> 0x80000000; each with out_valid 1 cycle after accept.
- Backpressure: out_ready held 0 for 5 cycles in DONE -> result stable, busy=1; out_ready=1 -> IDLE next edge.
- flush at CALC iteration 10 -> IDLE next edge, no out_valid. Async rst pulse mid-CALC -> all outputs reset immediately. A new op after either completes correctly.
